// File: rtl/product_accumulator.sv
// Product accumulator: sums a batch of 8-bit multiplier products into an
// ACC_W-bit accumulator, then streams the sum out LSB byte first.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   start, len         batch request (sampled only in IDLE)
//   prod_valid, prod   product input stream
//   prod_ready         asserted while accumulating
//   res_valid, res_ready, res_byte, res_last   result byte stream
//   busy               high while accumulating or emitting
//   ovf                sticky carry-out of the accumulator for the batch
module product_accumulator #(
    parameter int ACC_W = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             prod_valid,
    input  logic [7:0]       prod,
    output logic             prod_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_byte,
    output logic             res_last,
    output logic             busy,
    output logic             ovf
);

    localparam int NB = ACC_W / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] remaining;
    logic [BW-1:0]    byte_idx;

    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] acc_sh;
    logic             last_byte;

    // One extra bit captures the carry that feeds the sticky flag.
    assign sum       = {1'b0, acc} + (ACC_W+1)'(prod);
    // Shift-based byte select keeps the index in range for every ACC_W.
    assign acc_sh    = acc >> {byte_idx, 3'b000};
    assign last_byte = (byte_idx == BW'(NB - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            remaining <= '0;
            byte_idx  <= '0;
            ovf       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc       <= '0;
                        ovf       <= 1'b0;
                        byte_idx  <= '0;
                        remaining <= len;
                        state     <= (len != '0) ? ACCUM : OUT;
                    end
                end
                ACCUM: begin
                    if (prod_valid) begin
                        acc       <= sum[ACC_W-1:0];
                        remaining <= remaining - 1'b1;
                        if (sum[ACC_W]) begin
                            ovf <= 1'b1;
                        end
                        if (remaining == CNT_W'(1)) begin
                            state <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        if (last_byte) begin
                            state <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake outputs decode directly from the state register.
    assign prod_ready = (state == ACCUM);
    assign res_valid  = (state == OUT);
    assign busy       = (state != IDLE);
    assign res_last   = (state == OUT) && last_byte;
    assign res_byte   = (state == OUT) ? acc_sh[7:0] : 8'h00;

endmodule

// File: tb/tb_product_accumulator.sv
// Testbench for product_accumulator: a 16-bit and an 8-bit accumulator share
// the same stimulus; directed batch table plus multi-cycle corner sequences.
module tb_product_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] len;
    logic       prod_valid;
    logic [7:0] prod;
    logic       res_ready;

    logic       prod_ready16, res_valid16, res_last16, busy16, ovf16;
    logic [7:0] res_byte16;
    logic       prod_ready8, res_valid8, res_last8, busy8, ovf8;
    logic [7:0] res_byte8;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    product_accumulator #(.ACC_W(16), .CNT_W(4)) dut16 (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .prod_valid (prod_valid),
        .prod       (prod),
        .prod_ready (prod_ready16),
        .res_valid  (res_valid16),
        .res_ready  (res_ready),
        .res_byte   (res_byte16),
        .res_last   (res_last16),
        .busy       (busy16),
        .ovf        (ovf16)
    );

    product_accumulator #(.ACC_W(8), .CNT_W(4)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .prod_valid (prod_valid),
        .prod       (prod),
        .prod_ready (prod_ready8),
        .res_valid  (res_valid8),
        .res_ready  (res_ready),
        .res_byte   (res_byte8),
        .res_last   (res_last8),
        .busy       (busy8),
        .ovf        (ovf8)
    );

    typedef struct {
        int              len;
        logic [3:0][7:0] p;
        logic [15:0]     exp16;
        logic [7:0]      exp8;
        logic            ovf8;
    } vec_t;

    vec_t tbl [6];

    function automatic vec_t mk(input int l, input logic [7:0] a,
                                input logic [7:0] b, input logic [7:0] c,
                                input logic [7:0] d, input logic [15:0] e16,
                                input logic [7:0] e8, input logic o);
        vec_t v;
        v.len   = l;
        v.p[0]  = a;
        v.p[1]  = b;
        v.p[2]  = c;
        v.p[3]  = d;
        v.exp16 = e16;
        v.exp8  = e8;
        v.ovf8  = o;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_zero16(input string nm);
        chk({nm, "_prod_ready"}, 16'(prod_ready16), 16'h0);
        chk({nm, "_res_valid"},  16'(res_valid16),  16'h0);
        chk({nm, "_res_byte"},   16'(res_byte16),   16'h0);
        chk({nm, "_res_last"},   16'(res_last16),   16'h0);
        chk({nm, "_busy"},       16'(busy16),       16'h0);
        chk({nm, "_ovf"},        16'(ovf16),        16'h0);
        chk({nm, "_ovf8"},       16'(ovf8),         16'h0);
        chk({nm, "_busy8"},      16'(busy8),        16'h0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        len        = 4'd0;
        prod_valid = 1'b0;
        prod       = 8'h00;
        res_ready  = 1'b1;

        // Values sum by hand: 0F+E1+01=F1; E1+20=101; 4*FF=3FC;
        // 10+20+30+40=A0; 3*E1=2A3.
        tbl[0] = mk(3, 8'h0F, 8'hE1, 8'h01, 8'h00, 16'h00F1, 8'hF1, 1'b0);
        tbl[1] = mk(2, 8'hE1, 8'h20, 8'h00, 8'h00, 16'h0101, 8'h01, 1'b1);
        tbl[2] = mk(4, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 16'h03FC, 8'hFC, 1'b1);
        tbl[3] = mk(1, 8'h80, 8'h00, 8'h00, 8'h00, 16'h0080, 8'h80, 1'b0);
        tbl[4] = mk(4, 8'h10, 8'h20, 8'h30, 8'h40, 16'h00A0, 8'hA0, 1'b0);
        tbl[5] = mk(3, 8'hE1, 8'hE1, 8'hE1, 8'h00, 16'h02A3, 8'hA3, 1'b1);

        #1;
        chk_zero16("reset");
        tick;
        tick;
        rst = 1'b0;
        tick;

        // Table of back-to-back batches with res_ready held high.
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                chk("ovf8_hold_idle", 16'(ovf8), 16'(tbl[i-1].ovf8));
            end
            chk("idle_busy", 16'(busy16), 16'h0);
            start = 1'b1;
            len   = 4'(tbl[i].len);
            tick;
            start = 1'b0;
            len   = 4'd0;
            chk("ovf8_clr_on_start", 16'(ovf8), 16'h0);
            chk("accum_prod_ready", 16'(prod_ready16), 16'h1);
            chk("accum_busy", 16'(busy16), 16'h1);
            for (int j = 0; j < tbl[i].len; j++) begin
                prod_valid = 1'b1;
                prod       = tbl[i].p[j];
                tick;
            end
            prod_valid = 1'b0;
            prod       = 8'h00;
            chk("out_res_valid", 16'(res_valid16), 16'h1);
            chk("out_prod_ready", 16'(prod_ready16), 16'h0);
            chk("out_byte0", 16'(res_byte16), 16'(tbl[i].exp16[7:0]));
            chk("out_last0", 16'(res_last16), 16'h0);
            chk("out8_byte", 16'(res_byte8), 16'(tbl[i].exp8));
            chk("out8_last", 16'(res_last8), 16'h1);
            chk("out8_ovf", 16'(ovf8), 16'(tbl[i].ovf8));
            chk("out_ovf16", 16'(ovf16), 16'h0);
            tick;
            chk("out_byte1", 16'(res_byte16), 16'(tbl[i].exp16[15:8]));
            chk("out_last1", 16'(res_last16), 16'h1);
            chk("idle8_busy", 16'(busy8), 16'h0);
            chk("idle8_ovf_held", 16'(ovf8), 16'(tbl[i].ovf8));
            tick;
            chk("done_busy", 16'(busy16), 16'h0);
            chk("done_res_valid", 16'(res_valid16), 16'h0);
            tick;
        end

        // len=0: straight to OUT with a zero result, never accepting products.
        start = 1'b1;
        len   = 4'd0;
        prod_valid = 1'b1;
        prod  = 8'h55;
        chk("len0_pre_prod_ready", 16'(prod_ready16), 16'h0);
        tick;
        start = 1'b0;
        prod_valid = 1'b0;
        chk("len0_prod_ready", 16'(prod_ready16), 16'h0);
        chk("len0_res_valid", 16'(res_valid16), 16'h1);
        chk("len0_byte0", 16'(res_byte16), 16'h00);
        chk("len0_last0", 16'(res_last16), 16'h0);
        chk("len0_ovf", 16'(ovf16), 16'h0);
        tick;
        chk("len0_prod_ready1", 16'(prod_ready16), 16'h0);
        chk("len0_byte1", 16'(res_byte16), 16'h00);
        chk("len0_last1", 16'(res_last16), 16'h1);
        tick;
        chk("len0_done", 16'(busy16), 16'h0);

        // Gapped products (12+34=46) and a 3-cycle output stall.
        res_ready = 1'b0;
        start = 1'b1;
        len   = 4'd2;
        tick;
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            prod_valid = 1'b0;
            prod       = 8'hFF;
            tick;
            tick;
            chk("gap_still_accum", 16'(prod_ready16), 16'h1);
            prod_valid = 1'b1;
            prod       = (k == 0) ? 8'h12 : 8'h34;
            tick;
        end
        prod_valid = 1'b0;
        prod       = 8'h00;
        for (int k = 0; k < 3; k++) begin
            chk("stall_valid", 16'(res_valid16), 16'h1);
            chk("stall_byte", 16'(res_byte16), 16'h46);
            chk("stall_last", 16'(res_last16), 16'h0);
            tick;
        end
        res_ready = 1'b1;
        chk("stall_byte0_after", 16'(res_byte16), 16'h46);
        tick;
        chk("stall_byte1", 16'(res_byte16), 16'h00);
        chk("stall_last1", 16'(res_last16), 16'h1);
        tick;
        chk("stall_done", 16'(busy16), 16'h0);

        // Asynchronous reset in the middle of a batch.
        start = 1'b1;
        len   = 4'd3;
        tick;
        start = 1'b0;
        prod_valid = 1'b1;
        prod  = 8'h05;
        tick;
        prod  = 8'h07;
        #2;
        rst = 1'b1;
        #1;
        chk_zero16("async_rst");
        rst = 1'b0;
        prod_valid = 1'b0;
        tick;
        chk("post_rst_idle", 16'(busy16), 16'h0);
        start = 1'b1;
        len   = 4'd1;
        tick;
        start = 1'b0;
        prod_valid = 1'b1;
        prod  = 8'h09;
        tick;
        prod_valid = 1'b0;
        chk("rst_batch_byte0", 16'(res_byte16), 16'h09);
        tick;
        chk("rst_batch_byte1", 16'(res_byte16), 16'h00);
        chk("rst_batch_last1", 16'(res_last16), 16'h1);
        tick;

        // start/len pulsed during ACCUM and OUT must be ignored (1+2+3=6).
        start = 1'b1;
        len   = 4'd3;
        tick;
        len   = 4'd5;
        prod_valid = 1'b1;
        prod  = 8'h01;
        tick;
        prod  = 8'h02;
        tick;
        start = 1'b0;
        prod  = 8'h03;
        tick;
        prod_valid = 1'b0;
        res_ready  = 1'b0;
        start = 1'b1;
        chk("ign_res_valid", 16'(res_valid16), 16'h1);
        chk("ign_byte0", 16'(res_byte16), 16'h06);
        tick;
        start = 1'b0;
        chk("ign_byte0_held", 16'(res_byte16), 16'h06);
        chk("ign_last0", 16'(res_last16), 16'h0);
        res_ready = 1'b1;
        tick;
        chk("ign_byte1", 16'(res_byte16), 16'h00);
        chk("ign_last1", 16'(res_last16), 16'h1);
        tick;
        chk("ign_done", 16'(busy16), 16'h0);
        tick;
        chk("ign_stay_idle", 16'(busy16), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
